// File: rtl/avr_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : avr_pkg                                                   |
// | Purpose  : Shared AVR fetch constants and two-word opcode decode     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package avr_pkg;

   localparam int          c_PC_W_DEFAULT = 16;
   localparam logic [15:0] c_NOP          = 16'h0000;

   // LDS/STS share a mask; JMP/CALL share a mask that ignores bit 0
   localparam logic [15:0] c_LDS_STS_MASK = 16'hFE0F;
   localparam logic [15:0] c_LDS_PAT      = 16'h9000;
   localparam logic [15:0] c_STS_PAT      = 16'h9200;
   localparam logic [15:0] c_JMP_CALL_MASK = 16'hFE0E;
   localparam logic [15:0] c_JMP_PAT      = 16'h940C;
   localparam logic [15:0] c_CALL_PAT     = 16'h940E;

   function automatic logic is_two_word(input logic [15:0] word);
      return ((word & c_LDS_STS_MASK) == c_LDS_PAT)  ||
             ((word & c_LDS_STS_MASK) == c_STS_PAT)  ||
             ((word & c_JMP_CALL_MASK) == c_JMP_PAT) ||
             ((word & c_JMP_CALL_MASK) == c_CALL_PAT);
   endfunction

endpackage
`default_nettype wire

// File: rtl/avr_prefetch_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : avr_prefetch_fifo                                         |
// | Purpose  : {pc, word} instruction queue, pop 0/1/2, head+1 peek      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module avr_prefetch_fifo
   import avr_pkg::*;
#(
   parameter int PC_W  = c_PC_W_DEFAULT,
   parameter int DEPTH = 4
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     flush,
   input  logic                     push,
   input  logic [PC_W-1:0]          push_pc,
   input  logic [15:0]              push_word,
   input  logic [1:0]               pop_n,
   output logic [$clog2(DEPTH):0]   count,
   output logic [PC_W-1:0]          head_pc,
   output logic [15:0]              head_word,
   output logic [15:0]              next_word
);

   localparam int AW = $clog2(DEPTH);

   logic [PC_W-1:0] r_pc_mem   [DEPTH];
   logic [15:0]     r_word_mem [DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [AW:0]     r_count;
   logic [AW-1:0]   w_rd_next;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_pc_mem[i]   <= '0;
            r_word_mem[i] <= '0;
         end
      end else if (push && !flush) begin
         r_pc_mem[r_wr_ptr]   <= push_pc;
         r_word_mem[r_wr_ptr] <= push_word;
      end
   end

   // Power-of-two depth lets the pointers wrap by plain overflow
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (push)
            r_wr_ptr <= r_wr_ptr + AW'(1);
         r_rd_ptr <= r_rd_ptr + AW'(pop_n);
         r_count  <= r_count + (AW+1)'(push) - (AW+1)'(pop_n);
      end
   end

   assign w_rd_next = r_rd_ptr + AW'(1);
   assign count     = r_count;
   assign head_pc   = r_pc_mem[r_rd_ptr];
   assign head_word = r_word_mem[r_rd_ptr];
   assign next_word = r_word_mem[w_rd_next];

endmodule
`default_nettype wire

// File: rtl/avr_prefetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : avr_prefetch                                              |
// | Purpose  : AVR instruction prefetch queue with two-word assembly     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module avr_prefetch
   import avr_pkg::*;
#(
   parameter int              PC_W     = c_PC_W_DEFAULT,
   parameter int              DEPTH    = 4,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            CLK,
   input  logic            RST,
   output logic [PC_W-1:0] prog_addr,
   output logic            prog_req,
   input  logic [15:0]     prog_data,
   input  logic            redirect,
   input  logic [PC_W-1:0] redirect_pc,
   output logic            instr_valid,
   input  logic            instr_take,
   output logic [15:0]     cur_instr,
   output logic [15:0]     cur_instr2,
   output logic            instr_is32,
   output logic [PC_W-1:0] cur_pc
);

   localparam int          AW      = $clog2(DEPTH);
   localparam logic [AW+1:0] c_DEPTH = (AW+2)'(DEPTH);

   logic [PC_W-1:0] r_fetch_pc;
   logic [PC_W-1:0] r_issued_pc;
   logic            r_inflight;

   logic [AW:0]     w_count;
   logic [PC_W-1:0] w_head_pc;
   logic [15:0]     w_head_word;
   logic [15:0]     w_next_word;
   logic            w_nonempty;
   logic            w_is32;
   logic            w_valid;
   logic [1:0]      w_pop_n;
   logic [AW+1:0]   w_occ;
   logic            w_push;

   avr_prefetch_fifo #(
      .PC_W  (PC_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .CLK       (CLK),
      .RST       (RST),
      .flush     (redirect),
      .push      (w_push),
      .push_pc   (r_issued_pc),
      .push_word (prog_data),
      .pop_n     (w_pop_n),
      .count     (w_count),
      .head_pc   (w_head_pc),
      .head_word (w_head_word),
      .next_word (w_next_word)
   );

   assign w_nonempty = (w_count != '0);
   assign w_is32     = w_nonempty && is_two_word(w_head_word);
   assign w_valid    = w_is32 ? (w_count >= (AW+1)'(2)) : w_nonempty;
   assign w_pop_n    = (!redirect && instr_take && w_valid) ? (w_is32 ? 2'd2 : 2'd1) : 2'd0;

   // Occupancy after this cycle's pop, counting the response landing now
   assign w_occ    = (AW+2)'(w_count) + (AW+2)'(r_inflight) - (AW+2)'(w_pop_n);
   assign prog_req = !RST && (redirect || (w_occ < c_DEPTH));
   assign prog_addr = RST ? RESET_PC : (redirect ? redirect_pc : r_fetch_pc);
   assign w_push   = r_inflight && !redirect;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_fetch_pc  <= RESET_PC;
         r_issued_pc <= '0;
         r_inflight  <= 1'b0;
      end else begin
         r_inflight <= prog_req;
         if (prog_req) begin
            r_issued_pc <= prog_addr;
            r_fetch_pc  <= prog_addr + PC_W'(1);
         end
      end
   end

   assign instr_valid = w_valid;
   assign instr_is32  = w_is32;
   assign cur_instr   = w_nonempty ? w_head_word : c_NOP;
   assign cur_instr2  = w_is32 ? w_next_word : 16'h0000;
   assign cur_pc      = w_nonempty ? w_head_pc : '0;

endmodule
`default_nettype wire

// File: tb/tb_avr_prefetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_avr_prefetch                                           |
// | Purpose  : Directed self-checking bench for avr_prefetch             |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_avr_prefetch;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [15:0] prog_addr;
   logic        prog_req;
   logic [15:0] prog_data = 16'hDEAD;
   logic        redirect = 1'b0;
   logic [15:0] redirect_pc = 16'h0000;
   logic        instr_valid;
   logic        instr_take = 1'b0;
   logic [15:0] cur_instr;
   logic [15:0] cur_instr2;
   logic        instr_is32;
   logic [15:0] cur_pc;

   int n_checks = 0;
   int n_fail   = 0;

   avr_prefetch #(
      .PC_W     (16),
      .DEPTH    (4),
      .RESET_PC (16'h0000)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .prog_addr   (prog_addr),
      .prog_req    (prog_req),
      .prog_data   (prog_data),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .instr_valid (instr_valid),
      .instr_take  (instr_take),
      .cur_instr   (cur_instr),
      .cur_instr2  (cur_instr2),
      .instr_is32  (instr_is32),
      .cur_pc      (cur_pc)
   );

   always #5 CLK = ~CLK;

   // Program memory: word n = n, except a JMP 0x0123 at address 4
   function automatic logic [15:0] mem_word(input logic [15:0] a);
      if (a == 16'h0004) return 16'h940C;
      if (a == 16'h0005) return 16'h0123;
      return a;
   endfunction

   always @(posedge CLK)
      prog_data <= prog_req ? mem_word(prog_addr) : 16'hDEAD;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input logic take, input logic redir, input logic [15:0] rpc);
      @(negedge CLK);
      instr_take  = take;
      redirect    = redir;
      redirect_pc = rpc;
      #1;
   endtask

   task automatic release_rst(input logic take);
      @(negedge CLK);
      RST        = 1'b0;
      instr_take = take;
      redirect   = 1'b0;
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, ".req"},   32'(prog_req),    32'h0);
      check({tag, ".addr"},  32'(prog_addr),   32'h0);
      check({tag, ".valid"}, 32'(instr_valid), 32'h0);
      check({tag, ".instr"}, 32'(cur_instr),   32'h0);
      check({tag, ".instr2"},32'(cur_instr2),  32'h0);
      check({tag, ".is32"},  32'(instr_is32),  32'h0);
      check({tag, ".pc"},    32'(cur_pc),      32'h0);
   endtask

   task automatic check_head(input string tag, input logic v, input logic [15:0] pc,
                             input logic [15:0] ins);
      check({tag, ".valid"}, 32'(instr_valid), 32'(v));
      if (v) begin
         check({tag, ".pc"},    32'(cur_pc),    32'(pc));
         check({tag, ".instr"}, 32'(cur_instr), 32'(ins));
      end
   endtask

   task automatic do_reset();
      RST = 1'b1;
      instr_take = 1'b0;
      redirect   = 1'b0;
      repeat (2) @(negedge CLK);
   endtask

   // Expected head per cycle for straight-line fetch with take every cycle
   logic [15:0] t1_pc   [10] = '{16'h0, 16'h0, 16'h0, 16'h1, 16'h2, 16'h3, 16'h4, 16'h4, 16'h6, 16'h7};
   logic        t1_val  [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
   logic [15:0] t1_ins  [10] = '{16'h0, 16'h0, 16'h0, 16'h1, 16'h2, 16'h3, 16'h0, 16'h940C, 16'h6, 16'h7};

   initial begin
      // reset state
      do_reset();
      #1;
      check_reset_outputs("rst");

      // straight-line fetch with JMP at 4
      release_rst(1'b1);
      for (int k = 0; k < 10; k++) begin
         if (k > 0) cyc(1'b1, 1'b0, 16'h0);
         check($sformatf("t1.c%0d.req", k), 32'(prog_req), 32'h1);
         check($sformatf("t1.c%0d.addr", k), 32'(prog_addr), 32'(k));
         check_head($sformatf("t1.c%0d", k), t1_val[k], t1_pc[k], t1_ins[k]);
         if (k == 6) check("t1.c6.is32_wait", 32'(instr_is32), 32'h1);
         if (k == 7) begin
            check("t1.c7.is32", 32'(instr_is32), 32'h1);
            check("t1.c7.instr2", 32'(cur_instr2), 32'h0123);
         end
         if (k == 8) check("t1.c8.is32", 32'(instr_is32), 32'h0);
      end

      // stall until full, then drain in order
      do_reset();
      release_rst(1'b0);
      for (int k = 0; k < 10; k++) begin
         if (k > 0) cyc(1'b0, 1'b0, 16'h0);
         check($sformatf("t3.c%0d.req", k), 32'(prog_req), (k < 4) ? 32'h1 : 32'h0);
         check($sformatf("t3.c%0d.addr", k), 32'(prog_addr), (k < 4) ? 32'(k) : 32'h4);
      end
      for (int k = 0; k < 4; k++) begin
         cyc(1'b1, 1'b0, 16'h0);
         check_head($sformatf("t3.d%0d", k), 1'b1, 16'(k), 16'(k));
         if (k == 0) begin
            check("t3.d0.req", 32'(prog_req), 32'h1);
            check("t3.d0.addr", 32'(prog_addr), 32'h4);
         end
      end

      // redirect while the read of 3 is in flight
      do_reset();
      release_rst(1'b0);
      for (int k = 1; k < 4; k++) cyc(1'b0, 1'b0, 16'h0);
      check("t4.addr3", 32'(prog_addr), 32'h3);
      cyc(1'b1, 1'b1, 16'h0040);
      check("t4.redir.req", 32'(prog_req), 32'h1);
      check("t4.redir.addr", 32'(prog_addr), 32'h0040);
      cyc(1'b1, 1'b0, 16'h0);
      check("t4.r1.valid", 32'(instr_valid), 32'h0);
      check("t4.r1.addr", 32'(prog_addr), 32'h0041);
      cyc(1'b1, 1'b0, 16'h0);
      check_head("t4.r2", 1'b1, 16'h0040, 16'h0040);
      cyc(1'b1, 1'b0, 16'h0);
      check_head("t4.r3", 1'b1, 16'h0041, 16'h0041);

      // redirect near the top of the address space wraps to 0
      cyc(1'b0, 1'b1, 16'hFFFE);
      check("t5.redir.addr", 32'(prog_addr), 32'hFFFE);
      cyc(1'b1, 1'b0, 16'h0);
      check("t5.r1.valid", 32'(instr_valid), 32'h0);
      check("t5.r1.addr", 32'(prog_addr), 32'hFFFF);
      cyc(1'b1, 1'b0, 16'h0);
      check_head("t5.r2", 1'b1, 16'hFFFE, 16'hFFFE);
      check("t5.r2.addr", 32'(prog_addr), 32'h0000);
      cyc(1'b1, 1'b0, 16'h0);
      check_head("t5.r3", 1'b1, 16'hFFFF, 16'hFFFF);
      cyc(1'b1, 1'b0, 16'h0);
      check_head("t5.r4", 1'b1, 16'h0000, 16'h0000);

      // asynchronous reset mid-fill with three entries queued
      do_reset();
      release_rst(1'b0);
      for (int k = 1; k < 5; k++) cyc(1'b0, 1'b0, 16'h0);
      check_head("t6.pre", 1'b1, 16'h0000, 16'h0000);
      #1 RST = 1'b1;
      #1;
      check_reset_outputs("t6.async");
      release_rst(1'b0);
      check("t6.c0.req", 32'(prog_req), 32'h1);
      check("t6.c0.addr", 32'(prog_addr), 32'h0);
      check("t6.c0.valid", 32'(instr_valid), 32'h0);
      cyc(1'b0, 1'b0, 16'h0);
      check("t6.c1.valid", 32'(instr_valid), 32'h0);
      cyc(1'b0, 1'b0, 16'h0);
      check_head("t6.c2", 1'b1, 16'h0000, 16'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
